// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial source stage for the seq_mealy detector.
// Words arrive on a valid/ready handshake and leave one bit per enabled clock.
// The next word can be loaded on the last bit's edge, so there is no idle gap.
module seq_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             en,
   output logic             out,
   output logic             out_valid,
   output logic             frame_done,
   output logic             busy
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sreg, sreg_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             out_nxt;
   logic             last_en;

   // The last bit is on the line and the line is advancing this cycle.
   assign last_en    = (state == SHIFT) && (cnt == LAST) && en;
   assign out_valid  = (state == SHIFT);
   assign busy       = out_valid;
   assign frame_done = last_en;
   assign din_ready  = (state == IDLE) || last_en;

   // Head bit of a shift-register image, honouring the transmit order.
   function automatic logic head_bit(input logic [WIDTH-1:0] v);
      return MSB_FIRST ? v[WIDTH-1] : v[0];
   endfunction

   // Move the next bit into the head position.
   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
      return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
   endfunction

   // State, shift register, bit counter and the registered serial output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         sreg  <= '0;
         cnt   <= '0;
         out   <= IDLE_BIT;
      end else begin
         state <= state_nxt;
         sreg  <= sreg_nxt;
         cnt   <= cnt_nxt;
         out   <= out_nxt;
      end
   end

   // Next-state: accept in IDLE regardless of en; in SHIFT advance only on en.
   always_comb begin
      state_nxt = state;
      sreg_nxt  = sreg;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (din_valid) begin
               state_nxt = SHIFT;
               sreg_nxt  = din;
               cnt_nxt   = '0;
            end
         end
         SHIFT: begin
            if (en) begin
               if (cnt != LAST) begin
                  sreg_nxt = advance(sreg);
                  cnt_nxt  = cnt + CW'(1);
               end else if (din_valid) begin
                  sreg_nxt = din;
                  cnt_nxt  = '0;
               end else begin
                  state_nxt = IDLE;
                  sreg_nxt  = '0;
                  cnt_nxt   = '0;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            sreg_nxt  = '0;
            cnt_nxt   = '0;
         end
      endcase
      out_nxt = (state_nxt == SHIFT) ? head_bit(sreg_nxt) : IDLE_BIT;
   end

endmodule

// File: tb/tb_seq_serializer.sv
// tb_seq_serializer: directed bench for seq_serializer with an MSB-first and an
// LSB-first instance sharing stimulus, a bits-remaining reference model checked
// every cycle, and literal expectations for each directed scenario.
module tb_seq_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic       din_valid;
   logic       en;
   logic       out_m, vld_m, fd_m, rdy_m, busy_m;
   logic       out_l, vld_l, fd_l, rdy_l, busy_l;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   // Reference model: bits remaining in the current word and the word itself.
   int         rem;
   logic [7:0] mword;
   int         k;
   logic       exp_m, exp_l, exp_v, exp_fd, exp_rdy;

   logic [31:0] om, ol, rd, fd;
   int          vc;

   always #5 clk = ~clk;

   seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
      .en(en), .out(out_m), .out_valid(vld_m), .frame_done(fd_m), .busy(busy_m));

   seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
      .en(en), .out(out_l), .out_valid(vld_l), .frame_done(fd_l), .busy(busy_l));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h time=%0t", nm, act, exp, $time);
      end
   endtask

   // Model update: a word is taken when idle, or on the final enabled bit.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rem   <= 0;
         mword <= 8'h00;
      end else if (rem == 0) begin
         if (din_valid) begin
            mword <= din;
            rem   <= 8;
         end
      end else if (en) begin
         if (rem == 1) begin
            if (din_valid) begin
               mword <= din;
               rem   <= 8;
            end else begin
               rem <= 0;
            end
         end else begin
            rem <= rem - 1;
         end
      end
   end

   // Expected outputs derived from the model.
   always_comb begin
      k       = 8 - rem;
      exp_m   = 1'b0;
      exp_l   = 1'b0;
      if (rem > 0) begin
         exp_m = mword[7-k];
         exp_l = mword[k];
      end
      exp_v   = (rem > 0);
      exp_fd  = (rem == 1) && en;
      exp_rdy = (rem == 0) || ((rem == 1) && en);
   end

   // Per-cycle comparison on the falling edge.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("model_out_m", {31'd0, out_m}, {31'd0, exp_m});
         chk("model_out_l", {31'd0, out_l}, {31'd0, exp_l});
         chk("model_valid", {30'd0, vld_m, vld_l}, {30'd0, exp_v, exp_v});
         chk("model_busy", {30'd0, busy_m, busy_l}, {30'd0, exp_v, exp_v});
         chk("model_frame_done", {30'd0, fd_m, fd_l}, {30'd0, exp_fd, exp_fd});
         chk("model_din_ready", {30'd0, rdy_m, rdy_l}, {30'd0, exp_rdy, exp_rdy});
      end
   end

   task automatic start(input logic [7:0] w, input bit keep);
      @(posedge clk); #1;
      din       = w;
      din_valid = 1'b1;
      @(posedge clk); #1;
      if (!keep) din_valid = 1'b0;
   endtask

   task automatic capture(input int n, input int drop_at, input int off_at, input int on_at,
                          input int w2_at, input logic [7:0] w2);
      om = '0; ol = '0; rd = '0; fd = '0; vc = 0;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         om = {om[30:0], out_m};
         ol = {ol[30:0], out_l};
         rd = {rd[30:0], rdy_m};
         fd = {fd[30:0], fd_m};
         vc += int'(vld_m);
         @(posedge clk); #1;
         if (i == drop_at) din_valid = 1'b0;
         if (i == w2_at)   din = w2;
         if (i == off_at)  en = 1'b0;
         if (i == on_at)   en = 1'b1;
      end
   endtask

   initial begin
      rst = 1'b1; din = 8'h00; din_valid = 1'b0; en = 1'b1;
      #12 rst = 1'b0;
      #1 chk_on = 1'b1;
      chk("reset_out", {29'd0, out_m, out_l, vld_m}, 32'd0);
      chk("reset_ready", {30'd0, rdy_m, fd_m}, 32'd2);

      // Single word 8'hB2, en held high.
      start(8'hB2, 1'b0);
      capture(9, 0, 0, 0, 0, 8'h00);
      chk("b2_msb_bits", om, 32'h164);
      chk("b2_lsb_bits", ol, 32'h09A);
      chk("b2_valid_cycles", vc, 32'd8);
      chk("b2_frame_done", fd, 32'h002);
      chk("b2_ready", rd, 32'h003);

      // Back-to-back F0 then 0F with din_valid held.
      start(8'hF0, 1'b1);
      din = 8'h0F;
      capture(16, 8, 0, 0, 0, 8'h00);
      chk("b2b_bits", om, 32'h0000F00F);
      chk("b2b_ready", rd, 32'h0101);
      chk("b2b_frame_done", fd, 32'h0101);
      chk("b2b_valid_cycles", vc, 32'd16);

      // Bit order: 8'h01.
      start(8'h01, 1'b0);
      capture(8, 0, 0, 0, 0, 8'h00);
      chk("lsb_first_01", ol, 32'h80);
      chk("msb_first_01", om, 32'h01);

      // Stall: en low for 3 cycles while bit index 2 of 8'hA5 is on out.
      start(8'hA5, 1'b0);
      capture(12, 0, 2, 5, 0, 8'h00);
      chk("stall_bits", om, 32'hBCA);
      chk("stall_ready", rd, 32'h003);
      chk("stall_frame_done", fd, 32'h002);
      chk("stall_valid_cycles", vc, 32'd11);

      // Asynchronous reset while bit index 4 of 8'hFF is on out.
      start(8'hFF, 1'b0);
      #41;
      chk("pre_reset_bit", {30'd0, out_m, vld_m}, 32'd3);
      rst = 1'b1;
      #1;
      chk("async_reset_out", {28'd0, out_m, out_l, vld_m, busy_m}, 32'd0);
      chk("async_reset_ready", {31'd0, rdy_m}, 32'd1);
      #4;
      rst       = 1'b0;
      din       = 8'h81;
      din_valid = 1'b1;
      @(posedge clk); #1;
      din_valid = 1'b0;
      capture(9, 0, 0, 0, 0, 8'h00);
      chk("after_reset_bits", om, 32'h102);
      chk("after_reset_valid", vc, 32'd8);

      // Detector feed stream: B2, 6D, 00 with no gaps.
      start(8'hB2, 1'b1);
      din = 8'h6D;
      capture(25, 16, 0, 0, 8, 8'h00);
      chk("stream_bits", om, 32'h0164DA00);
      chk("stream_valid_cycles", vc, 32'd24);

      repeat (2) @(posedge clk);
      #1 chk_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
- Parallel-to-serial source stage that feeds the single-bit `in` port of the seq_mealy sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per enabled clock.
- Provides a bit-valid flag and an end-of-word pulse so detector results can be aligned to word boundaries.
- Replaces hand-toggled serial stimulus with a reproducible, word-driven bit stream.

Parameters:
- WIDTH, 8: bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.
- IDLE_BIT, 0: level driven on `out` when no word is being sent.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a word to transmit.
- din_ready  output  1  block can accept din this cycle.
- en  input  1  bit-rate enable; shifting advances only when en=1.
- out  output  1  serial bit; connects to the detector's `in`.
- out_valid  output  1  out carries a data bit.
- frame_done  output  1  high while the last bit of a word is on out and en=1.
- busy  output  1  equals out_valid.

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-high (rst).
- Reset: the following take effect immediately, independent of clk:
  - state=IDLE, out=IDLE_BIT, out_valid=0, busy=0, frame_done=0
  - shift register=0, bit counter cnt=0, din_ready=1.
- States:
  - IDLE: no word loaded.
  - SHIFT: a word is being sent; cnt (0..WIDTH-1) is the index of the bit currently on out.
- din_ready is combinational: `(state==IDLE) | (state==SHIFT & cnt==WIDTH-1 & en)`.
- Accept: a word is accepted on a rising edge where din_valid & din_ready.
  - In IDLE, acceptance ignores en.
- Latency: the first bit of an accepted word is on out in the cycle after the accept edge, with out_valid=1 and cnt=0.
  - out, out_valid and cnt are registered; out never depends combinationally on din.
- SHIFT with en=1 at an edge:
  - If cnt<WIDTH-1: shift, cnt+1, next bit driven.
  - If cnt==WIDTH-1 and din_valid: load the new word, cnt=0, first new bit driven. Back-to-back words produce no idle gap.
  - If cnt==WIDTH-1 and !din_valid: go to IDLE; out=IDLE_BIT, out_valid=0.
- SHIFT with en=0: all registers hold; out is stable for as many cycles as en stays low. frame_done=0 and din_ready=0 while en=0 in SHIFT.
- Bit order: MSB_FIRST=1 sends din[WIDTH-1] down to din[0]; MSB_FIRST=0 sends din[0] up to din[WIDTH-1].
- Word length: each word occupies exactly WIDTH enabled cycles on out.
- frame_done is combinational: `out_valid & cnt==WIDTH-1 & en`.
- din_valid while din_ready=0 is ignored. Upstream holds din/din_valid stable until accepted; no buffering beyond the one word in flight.
- Reset mid-word aborts the word. The partial bits are lost, and the next accepted word starts at cnt=0.
- din_valid asserted in the same cycle rst deasserts: accepted at the first rising edge after deassertion.

Test Plan:
- Reset, then WIDTH=8, MSB_FIRST=1, din=8'hB2 with din_valid for 1 cycle, en=1:
  - Cycles 1..8 after the accept edge: out=1,0,1,1,0,0,1,0.
  - out_valid high exactly 8 cycles; frame_done only in cycle 8; cycle 9: out=0, out_valid=0, din_ready=1.
- Back-to-back, din=8'hF0 then 8'h0F with din_valid held:
  - out=1111_0000_0000_1111 over 16 consecutive cycles.
  - din_ready=1 in cycles 8 and 16 only; frame_done pulses in cycles 8 and 16.
- MSB_FIRST=0, din=8'h01:
  - out=1,0,0,0,0,0,0,0.
- Stall, din=8'hA5 with en dropped for 3 cycles while bit index 2 is on out:
  - out holds 1 for 4 cycles total, with din_ready=0 and frame_done=0 during the stall.
  - Sequence then resumes 0,0,1,0,1; total out_valid cycles = 11.
- rst pulsed for 5 ns while bit index 4 of 8'hFF is on out:
  - out drops to 0 and out_valid to 0 before the next clock edge.
  - A following 8'h81 yields 1,0,0,0,0,0,0,1 from cnt=0.
- Integration, `out` wired to seq_mealy `in`, detector clocked by the same clk:
  - Stream words 8'hB2, 8'h6D, 8'h00.
  - Detector `out` must match the golden model run on the same 24-bit sequence, cycle for cycle.
